// File: rtl/io_pkg.sv
// Shared definitions for the board serial IO blocks.
package io_pkg;

  localparam int FRAME_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } p2s_state_t;

  // Counter width able to hold 0..n-1 without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seg_p2s_64_if.sv
// Frame request/status and board-pin bundle for seg_p2s_64.
interface seg_p2s_64_if #(
  parameter int WIDTH = io_pkg::FRAME_W
) ();

  logic             start;
  logic [WIDTH-1:0] par_data;
  logic             busy;
  logic             done;
  logic             s_clk;
  logic             s_dat;
  logic             s_latch;

  modport master (
    output start, par_data,
    input  busy, done, s_clk, s_dat, s_latch
  );

  modport slave (
    input  start, par_data,
    output busy, done, s_clk, s_dat, s_latch
  );

endinterface

// File: rtl/half_period_tick.sv
// DIV-cycle counter with sync clear; tick on the last cycle of each period.
module half_period_tick
  import io_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_p2s_64.sv
// MSB-first parallel-to-serial driver for the external display shift chain.
module seg_p2s_64
  import io_pkg::*;
#(
  parameter int WIDTH = FRAME_W,
  parameter int DIV   = 2
) (
  input logic         clk,
  input logic         rst,
  seg_p2s_64_if.slave io
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  p2s_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             busy_q;
  logic             done_q;
  logic             sclk_q;
  logic             latch_q;
  logic             tick;

  half_period_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (state != IDLE),
    .tick (tick)
  );

  // The MSB of the shift register is the pin; it only moves on load or shift.
  assign io.s_dat   = shreg[WIDTH-1];
  assign io.s_clk   = sclk_q;
  assign io.s_latch = latch_q;
  assign io.busy    = busy_q;
  assign io.done    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io.start) begin
            shreg   <= io.par_data;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            sclk_q <= 1'b1;
            state  <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              latch_q <= 1'b1;
              state   <= LATCH;
            end else begin
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (tick) begin
            latch_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_p2s_64.sv
// Self-checking bench for seg_p2s_64 (defaults and DIV=1/WIDTH=8).
module tb_seg_p2s_64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  seg_p2s_64_if #(.WIDTH(64)) bus0 ();
  seg_p2s_64_if #(.WIDTH(8))  bus1 ();

  seg_p2s_64 #(.WIDTH(64), .DIV(2)) u0 (
    .clk (clk),
    .rst (rst),
    .io  (bus0.slave)
  );

  seg_p2s_64 #(.WIDTH(8), .DIV(1)) u1 (
    .clk (clk),
    .rst (rst),
    .io  (bus1.slave)
  );

  // Model of the external chain: shift s_dat in on each s_clk rising edge.
  logic [63:0]       rx0;
  logic              pclk0;
  int                rise0;
  int                rise0_q[$];
  int                latch0_q[$];
  int                done0_q[$];
  int                nrise0_q[$];
  logic [63:0]       word0_q[$];

  logic [7:0]        rx1;
  logic              pclk1;
  int                rise1;
  int                rise1_q[$];
  int                latch1_q[$];
  int                done1_q[$];
  int                nrise1_q[$];
  logic [7:0]        word1_q[$];

  always @(negedge clk) begin
    if (rst) begin
      rx0 = '0; pclk0 = 1'b0; rise0 = 0;
      rx1 = '0; pclk1 = 1'b0; rise1 = 0;
    end else begin
      if (bus0.s_clk && !pclk0) begin
        rx0 = {rx0[62:0], bus0.s_dat};
        rise0++;
        rise0_q.push_back(edge_n);
      end
      pclk0 = bus0.s_clk;
      if (bus0.s_latch) latch0_q.push_back(edge_n);
      if (bus0.done) begin
        done0_q.push_back(edge_n);
        word0_q.push_back(rx0);
        nrise0_q.push_back(rise0);
        rise0 = 0;
      end
      if (bus1.s_clk && !pclk1) begin
        rx1 = {rx1[6:0], bus1.s_dat};
        rise1++;
        rise1_q.push_back(edge_n);
      end
      pclk1 = bus1.s_clk;
      if (bus1.s_latch) latch1_q.push_back(edge_n);
      if (bus1.done) begin
        done1_q.push_back(edge_n);
        word1_q.push_back(rx1);
        nrise1_q.push_back(rise1);
        rise1 = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int t0, rb, lb, db;

  task automatic accept0();
    @(negedge clk);
    #1;
    t0 = edge_n;
    rb = rise0_q.size();
    lb = latch0_q.size();
    db = done0_q.size();
    bus0.start = 1'b0;
    bus0.par_data = {$urandom, $urandom};
  endtask

  task automatic send0(input logic [63:0] d);
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.par_data = d;
    accept0();
  endtask

  task automatic wait_done0(input int n, input string tag, output int gaps);
    int k;
    k = 0;
    gaps = 0;
    while (done0_q.size() <= n && k < 400) begin
      @(negedge clk);
      #1;
      if (!bus0.busy && !bus0.done) gaps++;
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done0_q.size() > n), 64'd1);
  endtask

  // Expected timing from the frame rules: bit k rises at (2k+1)*DIV etc.
  task automatic frame0(input logic [63:0] d, input int a0, input int arb,
                        input int alb, input int adb, input string tag);
    int bad;
    int nl;
    bad = 0;
    nl = 0;
    chk({tag, "_word"}, word0_q[adb], d);
    chk({tag, "_nrise"}, 64'(nrise0_q[adb]), 64'd64);
    chk({tag, "_done_t"}, 64'(done0_q[adb] - a0), 64'd258);
    for (int k = 0; k < 64; k++)
      if (rise0_q[arb+k] - a0 != (2*k + 1) * 2) bad++;
    chk({tag, "_rise_t"}, 64'(bad), 64'd0);
    for (int k = alb; k < latch0_q.size(); k++)
      if (latch0_q[k] <= done0_q[adb]) nl++;
    chk({tag, "_latch_t"}, 64'(latch0_q[alb] - a0), 64'd256);
    chk({tag, "_latch_n"}, 64'(nl), 64'd2);
  endtask

  task automatic frame1(input logic [7:0] d, input string tag);
    int a0, arb, alb, adb, bad, k;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.par_data = d;
    @(negedge clk);
    #1;
    a0 = edge_n;
    arb = rise1_q.size();
    alb = latch1_q.size();
    adb = done1_q.size();
    bus1.start = 1'b0;
    bus1.par_data = 8'($urandom);
    k = 0;
    while (done1_q.size() <= adb && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done1_q.size() > adb), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (rise1_q[arb+i] - a0 != 2*i + 1) bad++;
    chk({tag, "_word"}, 64'(word1_q[adb]), 64'(d));
    chk({tag, "_nrise"}, 64'(nrise1_q[adb]), 64'd8);
    chk({tag, "_rise_t"}, 64'(bad), 64'd0);
    chk({tag, "_latch_t"}, 64'(latch1_q[alb] - a0), 64'd16);
    chk({tag, "_latch_n"}, 64'(latch1_q.size() - alb), 64'd1);
    chk({tag, "_done_t"}, 64'(done1_q[adb] - a0), 64'd17);
  endtask

  function automatic logic [4:0] outs0();
    return {bus0.busy, bus0.done, bus0.s_clk, bus0.s_dat, bus0.s_latch};
  endfunction

  initial begin
    int bad, gaps, n;
    int sa0, sarb, salb, sadb;
    logic [63:0] d;
    bus0.start = 1'b0;
    bus0.par_data = '0;
    bus1.start = 1'b0;
    bus1.par_data = '0;

    // reset and idle
    repeat (3) @(negedge clk);
    chk("reset_outs0", 64'(outs0()), 64'd0);
    chk("reset_outs1", 64'({bus1.busy, bus1.done, bus1.s_clk, bus1.s_latch}),
        64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs0() != 5'd0) bad++;
    end
    chk("idle_outs", 64'(bad), 64'd0);

    // single frame with the default parameters
    d = 64'hF0E1_D2C3_B4A5_9687;
    send0(d);
    chk("busy_after_accept", 64'(bus0.busy), 64'd1);
    wait_done0(db, "single", gaps);
    frame0(d, t0, rb, lb, db, "single");
    chk("single_busy_gaps", 64'(gaps), 64'd0);
    repeat (5) @(negedge clk);
    chk("single_one_done", 64'(done0_q.size()), 64'(db + 1));
    chk("hold_last_bit", 64'(bus0.s_dat), 64'(d[0]));

    // start during a frame is ignored
    d = 64'hFFFF_FFFF_FFFF_FFFF;
    send0(d);
    repeat (9) @(negedge clk);
    bus0.start = 1'b1;
    bus0.par_data = 64'h0;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (89) @(negedge clk);
    bus0.start = 1'b1;
    bus0.par_data = 64'h0;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_done0(db, "ignored", gaps);
    frame0(d, t0, rb, lb, db, "ignored");
    repeat (10) @(negedge clk);
    chk("ignored_one_done", 64'(done0_q.size()), 64'(db + 1));
    chk("ignored_idle", 64'(bus0.busy), 64'd0);

    // back-to-back frames: accept in the done cycle
    d = {$urandom, $urandom};
    send0(d);
    wait_done0(db, "b2b_a", gaps);
    bus0.start = 1'b1;
    bus0.par_data = 64'h1;
    sa0 = t0; sarb = rb; salb = lb; sadb = db;
    accept0();
    frame0(d, sa0, sarb, salb, sadb, "b2b_a");
    chk("b2b_accept_t", 64'(t0 - done0_q[sadb]), 64'd1);
    chk("b2b_busy", 64'(bus0.busy), 64'd1);
    wait_done0(db, "b2b_b", gaps);
    chk("b2b_busy_gaps", 64'(gaps), 64'd0);
    frame0(64'h1, t0, rb, lb, db, "b2b_b");

    // reset mid-frame
    send0({$urandom, $urandom});
    repeat (76) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outs", 64'(outs0()), 64'd0);
    n = done0_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", 64'(done0_q.size()), 64'(n));
    d = 64'hA5A5_A5A5_A5A5_A5A5;
    send0(d);
    wait_done0(db, "after_rst", gaps);
    frame0(d, t0, rb, lb, db, "after_rst");

    // randomized frames against the same rules
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      send0(d);
      wait_done0(db, $sformatf("rand%0d", i), gaps);
      frame0(d, t0, rb, lb, db, $sformatf("rand%0d", i));
    end

    // DIV=1, WIDTH=8 instance
    frame1(8'h81, "w8_81");
    frame1(8'($urandom), "w8_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_p2s_64.md
# seg_p2s_64

Parallel-to-serial transmitter that takes the selected 64-bit display word from the 2:1 display-source mux and shifts it MSB-first into the board's external shift-register chain. It drives the chain's serial clock, serial data and latch strobe. It then reports completion to the IO controller. It sits between the display-source mux output and the board pins.

## Interface
- `WIDTH`, 64: bits per frame; must be ≥ 2.
- `DIV`, 2: `clk` cycles per serial-clock half-period; must be ≥ 1.
- `clk` input 1: system clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to send `par_data`. Sampled only in IDLE.
- `par_data` input WIDTH: frame to send. Captured on the accepting edge; ignored afterwards.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse when a frame completes.
- `s_clk` output 1: serial clock. The external chain samples on its rising edge.
- `s_dat` output 1: serial data, MSB first.
- `s_latch` output 1: output-register latch strobe, high for DIV cycles after the last bit.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- Reset (async, any state): state=IDLE; `busy`, `done`, `s_clk`, `s_dat`, `s_latch` = 0; shift register and counters cleared. Reset mid-frame abandons the frame with no `done` pulse.
- IDLE with `start`=1:
  - shreg←`par_data`, `s_dat`←`par_data[WIDTH-1]`, bit_cnt←0, half_cnt←0, `s_clk`=0.
  - Go to SHIFT_LO.
- SHIFT_LO:
  - half_cnt counts 0..DIV-1.
  - On the edge where half_cnt=DIV-1: `s_clk`←1, half_cnt←0, go to SHIFT_HI.
- SHIFT_HI: at the end of DIV cycles, `s_clk`←0, then:
  - If bit_cnt=WIDTH-1: `s_latch`←1, go to LATCH.
  - Otherwise: shift shreg left, `s_dat`←next bit, bit_cnt+1, go to SHIFT_LO.
- LATCH: at the end of DIV cycles, `s_latch`←0, `done`←1 for one cycle, go to IDLE.
- `s_dat` changes only on `s_clk` falling edges, or on load. It is stable for DIV cycles either side of each `s_clk` rising edge.
- `start` while `busy` is ignored. No queuing.
- `start` in the cycle `done` is high is accepted; back-to-back frames are legal.
- `s_dat` holds the last bit after the frame, until the next load or reset.
- bit_cnt width is clog2(WIDTH). half_cnt width is clog2(DIV)+1. Neither counter wraps mid-frame.

## Timing
- Edge 0 is the edge that accepts `start`. `busy` is high from edge 0.
- Rising edge of `s_clk` for bit k: edge (2k+1)·DIV. Falling edge for bit k: edge (2k+2)·DIV.
- `s_latch` is high from edge 2·WIDTH·DIV to edge (2·WIDTH+1)·DIV.
- `done` is high for one cycle after edge (2·WIDTH+1)·DIV. `busy` falls on that same edge.
- Frame length: (2·WIDTH+1)·DIV cycles. With the defaults that is 258 cycles, with `done` high after edge 258.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `io_pkg`:
  - 2-bit state encoding (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3).
  - Default frame width constant (64), so the mux and this block agree.
- One natural sub-module: `half_period_tick`.
  - A DIV-cycle counter with sync clear.
  - Emits a `tick` on the last cycle of each half-period.
  - Reused by future serial IO blocks.
- Remaining RTL: FSM, shift register, bit counter.

## Test plan
- Reset and idle: hold `rst` high for 3 cycles, then release with `start`=0 for 20 cycles. Required: all outputs stay 0.
- Single frame, defaults: send `par_data`=64'hF0E1_D2C3_B4A5_9687. A bench-side 64-bit shift register clocked on `s_clk` rising edges must hold the same value when `s_latch` falls. `s_clk` must show exactly 64 rising edges. `done` must pulse exactly once, 258 cycles after the accepting edge.
- Ignored start: pulse `start` with 64'h0 at cycles 10 and 100 of a frame carrying 64'hFFFF_FFFF_FFFF_FFFF. Required: received word = all ones, one `done` pulse.
- Back-to-back: assert `start` in the `done` cycle with 64'h0000_0000_0000_0001. Required: `busy` stays high with no gap, and the second received word = 1.
- Reset mid-frame: assert `rst` at cycle 77. Required: outputs are 0 in the same cycle (before the next edge), no `done` pulse, and the next frame (64'hA5A5_A5A5_A5A5_A5A5) is received intact.
- Parameter sweep: DIV=1, WIDTH=8, send 8'h81. Required: `s_clk` rising edges at edges 1, 3, …, 15; `s_latch` high edges 16–17; `done` after edge 17.
